// File: rtl/mealy_pkg.sv
// Shared types and constants for the "0101" stream sequencer and its
// bit-serial Mealy detector.
//   det_state_t  : detector state, S0..S3 = 2'b00..2'b11 (matched-prefix length)
//   ctrl_state_t : word sequencer state IDLE / SHIFT / DONE
//   PATTERN      : the overlapping sequence being detected, first bit in [3]
package mealy_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ctrl_state_t;

    localparam logic [3:0] PATTERN = 4'b0101;

endpackage

// File: rtl/seq_detect_core.sv
// Bit-serial Mealy detector for the overlapping "0101" sequence.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-low reset, state -> S0
//   en      in  step the detector with bit_in this cycle
//   clr     in  force state to S0 at the next edge; wins over en
//   bit_in  in  current serial bit
//   det_out out combinational match flag for the current bit (S3 and bit_in==1)
module seq_detect_core
    import mealy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic det_out
);

    det_state_t state_q;
    det_state_t state_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Mealy output; state index is the matched prefix length of PATTERN
    always_comb begin
        state_d = state_q;
        det_out = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            case (state_q)
                S0: state_d = bit_in ? S0 : S1;
                S1: state_d = bit_in ? S2 : S1;
                S2: state_d = bit_in ? S0 : S3;
                S3: begin
                    state_d = bit_in ? S2 : S1;
                    det_out = bit_in;
                end
                default: state_d = S0;
            endcase
        end
    end

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Word sequencer around the "0101" Mealy detector: accepts WIDTH-bit words on a
// valid/ready handshake, shifts them MSB-first into the detector one bit per
// clock, and returns the per-word match count on a second valid/ready handshake.
// Optional feature macro: MATCH_MAP_EN adds the out_map port and map register.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   in_valid/ready  word handshake; in_ready is high only in IDLE
//   in_data         word, bit WIDTH-1 shifted first
//   cfg_keep_state  sampled at accept: 1 keeps detector state, 0 clears it to S0
//   out_valid/ready result handshake; result held stable until taken
//   out_count       number of matches in the word
//   out_map         match bitmap (MATCH_MAP_EN only)
module mealy_stream_ctrl
    import mealy_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_keep_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count
`ifdef MATCH_MAP_EN
    ,
    output logic [WIDTH-1:0] out_map
`endif
);

    localparam int unsigned BW = $clog2(WIDTH);

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic [CW-1:0]    count_q;
    logic             accept;
    logic             last_bit;
    logic             det_en;
    logic             det_clr;
    logic             det_out;

    // Next-state and datapath controls
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        det_en   = 1'b0;
        det_clr  = 1'b0;
        last_bit = (bitcnt_q == BW'(WIDTH - 1));
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    det_clr = !cfg_keep_state;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; handshake flags registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Shift register, bit counter and match count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            count_q  <= '0;
        end else if (accept) begin
            shreg_q  <= in_data;
            bitcnt_q <= '0;
            count_q  <= '0;
        end else if (det_en) begin
            shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_q <= bitcnt_q + BW'(1);
            if (det_out) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

`ifdef MATCH_MAP_EN
    logic [WIDTH-1:0] map_q;

    // Match bitmap: bit k in shift order lands at position WIDTH-1-k, aligned with in_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            map_q <= '0;
        end else if (accept) begin
            map_q <= '0;
        end else if (det_en && det_out) begin
            map_q[BW'(WIDTH - 1) - bitcnt_q] <= 1'b1;
        end
    end

    assign out_map = map_q;
`endif

    assign out_count = count_q;

    seq_detect_core u_det (
        .clk    (clk),
        .reset  (reset),
        .en     (det_en),
        .clr    (det_clr),
        .bit_in (shreg_q[WIDTH-1]),
        .det_out(det_out)
    );

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Self-checking bench for mealy_stream_ctrl (WIDTH=8). Expected results come
// from a bit-history model: a match is reported whenever the last four bits
// seen since the last clear spell 0101.
module tb_mealy_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       cfg_keep_state = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_count;
    logic [7:0] out_map;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [3:0] hist = 4'h0;
    int         hlen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef MATCH_MAP_EN
    mealy_stream_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_keep_state(cfg_keep_state), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_map(out_map)
    );
`else
    mealy_stream_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_keep_state(cfg_keep_state), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count)
    );
    assign out_map = 8'h00;
`endif

    // Reference: count positions where the stream since the last clear ends in 0101
    task automatic model_word(input logic [7:0] d, input logic k,
                              output int c, output logic [7:0] m);
        c = 0;
        m = 8'h00;
        if (!k) hlen = 0;
        for (int i = 0; i < 8; i++) begin
            hist = {hist[2:0], d[7-i]};
            hlen++;
            if (hlen >= 4 && hist == 4'b0101) begin
                c++;
                m[7-i] = 1'b1;
            end
        end
    endtask

    // One transaction from IDLE; optionally leaves the result untaken in DONE
    task automatic do_word(input logic [7:0] d, input logic k, input bit take,
                           output int cnt, output logic [7:0] mp,
                           output int lat, output bit acc_ok);
        int n;
        n = 0;
        in_data = d;
        cfg_keep_state = k;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        acc_ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_keep_state = 1'($urandom);
        in_data = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        cnt = int'(out_count);
        mp = out_map;
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", out_count); end
`ifdef MATCH_MAP_EN
        total++; if (out_map !== 8'h00) begin bad++; $display("FAIL reset_map: got %h expected 00", out_map); end
`endif
        reset = 1'b1;
        hlen = 0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_examples();
        int c; logic [7:0] m; int lat; bit ok; int mc; logic [7:0] mm;
        do_word(8'h55, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'h55, 1'b0, mc, mm);
        total++; if (!ok) begin bad++; $display("FAIL ex55_accept: got 0 expected 1"); end
        total++; if (c != 3) begin bad++; $display("FAIL ex55_count: got %0d expected 3", c); end
        total++; if (lat != 8) begin bad++; $display("FAIL ex55_latency: got %0d expected 8", lat); end
`ifdef MATCH_MAP_EN
        total++; if (m !== 8'h15) begin bad++; $display("FAIL ex55_map: got %h expected 15", m); end
`endif
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ex55_back_idle: got %b expected 1", in_ready); end

        do_word(8'hFF, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'hFF, 1'b0, mc, mm);
        total++; if (c != 0) begin bad++; $display("FAIL exFF_count: got %0d expected 0", c); end
`ifdef MATCH_MAP_EN
        total++; if (m !== 8'h00) begin bad++; $display("FAIL exFF_map: got %h expected 00", m); end
`endif
        do_word(8'h05, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'h05, 1'b0, mc, mm);
        total++; if (c != 1) begin bad++; $display("FAIL ex05_count: got %0d expected 1", c); end
`ifdef MATCH_MAP_EN
        total++; if (m !== 8'h01) begin bad++; $display("FAIL ex05_map: got %h expected 01", m); end
`endif
    endtask

    task automatic test_keep();
        int c; logic [7:0] m; int lat; bit ok; int mc; logic [7:0] mm;
        do_word(8'h02, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'h02, 1'b0, mc, mm);
        do_word(8'h80, 1'b1, 1'b1, c, m, lat, ok);
        model_word(8'h80, 1'b1, mc, mm);
        total++; if (c != 1) begin bad++; $display("FAIL keep1_count: got %0d expected 1", c); end
`ifdef MATCH_MAP_EN
        total++; if (m !== 8'h80) begin bad++; $display("FAIL keep1_map: got %h expected 80", m); end
`endif
        do_word(8'h02, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'h02, 1'b0, mc, mm);
        do_word(8'h80, 1'b0, 1'b1, c, m, lat, ok);
        model_word(8'h80, 1'b0, mc, mm);
        total++; if (c != 0) begin bad++; $display("FAIL keep0_count: got %0d expected 0", c); end
    endtask

    task automatic test_hold();
        int c; logic [7:0] m; int lat; bit ok; int mc; logic [7:0] mm; bit seen;
        do_word(8'h55, 1'b0, 1'b0, c, m, lat, ok);
        model_word(8'h55, 1'b0, mc, mm);
        in_valid = 1'b1;
        in_data = 8'h05;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            total++; if (out_count !== 4'd3) begin bad++; $display("FAIL hold_count[%0d]: got %0d expected 3", i, out_count); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b expected 0", out_valid); end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL ignored_word_consumed: got result expected none"); end
    endtask

    // Abort a word after n_bits bits, then run 'next' with keep=1
    task automatic abort_then(input logic [7:0] aborted, input int n_bits,
                              input logic [7:0] next, input int exp, input string tag);
        int c; logic [7:0] m; int lat; bit ok; int mc; logic [7:0] mm;
        in_data = aborted;
        cfg_keep_state = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n_bits) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_abort_valid: got %b expected 0", tag, out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_abort_in_ready: got %b expected 1", tag, in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        hlen = 0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_no_result: got %b expected 0", tag, out_valid); end
        do_word(next, 1'b1, 1'b1, c, m, lat, ok);
        model_word(next, 1'b1, mc, mm);
        total++; if (c != exp) begin bad++; $display("FAIL %s_after_reset_count: got %0d expected %0d", tag, c, exp); end
    endtask

    task automatic test_abort();
        abort_then(8'h55, 3, 8'h55, 3, "abort55");
        abort_then(8'h05, 7, 8'h80, 0, "abort05");
    endtask

    task automatic test_random();
        int c; logic [7:0] m; int lat; bit ok; int mc; logic [7:0] mm;
        logic [7:0] d; logic k; int gap;
        for (int w = 0; w < 40; w++) begin
            d = 8'($urandom);
            if (w % 4 == 0) d = 8'h55 ^ 8'($urandom_range(0, 15));
            k = 1'($urandom);
            do_word(d, k, 1'b0, c, m, lat, ok);
            model_word(d, k, mc, mm);
            total++; if (c != mc) begin bad++; $display("FAIL rand_count[%0d] d=%h k=%b: got %0d expected %0d", w, d, k, c, mc); end
            total++; if (lat != 8) begin bad++; $display("FAIL rand_latency[%0d]: got %0d expected 8", w, lat); end
`ifdef MATCH_MAP_EN
            total++; if (m !== mm) begin bad++; $display("FAIL rand_map[%0d] d=%h: got %h expected %h", w, d, m, mm); end
`endif
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_back_to_back();
        int acc_t[$]; int exp_c[$]; logic [7:0] exp_m[$];
        int c; logic [7:0] m; int ec; logic [7:0] em; int words; bit pend;
        logic [7:0] d;
        words = 0;
        out_ready = 1'b1;
        cfg_keep_state = 1'b1;
        d = 8'($urandom);
        in_data = d;
        in_valid = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (out_valid) begin
                if (exp_c.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_extra_result: got count %0d expected no result", out_count);
                end else begin
                    ec = exp_c.pop_front();
                    em = exp_m.pop_front();
                    total++; if (int'(out_count) != ec) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", out_count, ec); end
`ifdef MATCH_MAP_EN
                    total++; if (out_map !== em) begin bad++; $display("FAIL b2b_map: got %h expected %h", out_map, em); end
`endif
                end
            end
            pend = 1'b0;
            if (in_ready && in_valid) begin
                acc_t.push_back(cyc);
                model_word(d, 1'b1, c, m);
                exp_c.push_back(c);
                exp_m.push_back(m);
                words++;
                pend = 1'b1;
            end
            @(posedge clk); #1;
            if (pend) begin
                d = 8'($urandom);
                in_data = d;
                if (words == 4) in_valid = 1'b0;
            end
            if (words == 4 && exp_c.size() == 0) break;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        total++; if (words != 4) begin bad++; $display("FAIL b2b_words: got %0d expected 4", words); end
        total++; if (exp_c.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d expected 0", exp_c.size()); end
        for (int i = 1; i < acc_t.size(); i++) begin
            total++;
            if (acc_t[i] - acc_t[i-1] != 10) begin
                bad++;
                $display("FAIL b2b_interval[%0d]: got %0d expected 10", i, acc_t[i] - acc_t[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_examples();
        test_keep();
        test_hold();
        test_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
